// File: rtl/piso_pkg.sv
// Shared definitions for the framed parallel-in/serial-out controller:
// FSM state encoding, gap-counter width and a counter-width helper.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int GAP_CNT_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Load/shift/clear register, MSB-first, updated on the falling edge of CP.
// Clear wins over load, load wins over shift.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int   WIDTH = 4,
  parameter logic FILL  = 1'b0
) (
  input  logic             CP,
  input  logic             clr_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic             sclr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(negedge CP or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (sclr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], FILL};
    end
  end

endmodule

// File: rtl/piso_frame_ctrl.sv
// Frame sequencer around piso_shreg: valid/ready word intake, MSB-first
// serial shift-out with hold/abort, done pulse and an optional idle gap.
module piso_frame_ctrl
  import piso_pkg::*;
#(
  parameter int   WIDTH = 4,
  parameter int   GAP   = 1,
  parameter logic FILL  = 1'b0
) (
  input  logic                      CP,
  input  logic                      clr_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  input  logic                      hold,
  input  logic                      abort,
  output logic                      ser_out,
  output logic                      ser_valid,
  output logic                      busy,
  output logic                      done,
  output logic [clog2(WIDTH)-1:0]   bit_idx
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_INIT = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                 done_q;
  logic [WIDTH-1:0]     q;

  logic accept;
  logic step;
  logic last;

  // abort overrides every other event; hold only freezes SHIFT
  assign accept = (state == ST_IDLE)  && in_valid && !abort;
  assign step   = (state == ST_SHIFT) && !hold    && !abort;
  assign last   = step && (cnt == LAST_IDX);

  piso_shreg #(
    .WIDTH (WIDTH),
    .FILL  (FILL)
  ) u_shreg (
    .CP       (CP),
    .clr_n    (clr_n),
    .load     (accept),
    .shift_en (step),
    .sclr     (abort),
    .d        (in_data),
    .q        (q)
  );

  always_ff @(negedge CP or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (in_valid) state_nxt = ST_SHIFT;
        ST_SHIFT: if (!hold && (cnt == LAST_IDX)) state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
        ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // bit counter wraps to 0 on the last bit so it never exceeds WIDTH-1
  always_ff @(negedge CP or negedge clr_n) begin
    if (!clr_n) begin
      cnt     <= '0;
      gap_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (abort) begin
        cnt     <= '0;
        gap_cnt <= '0;
      end else begin
        if (accept) begin
          cnt <= '0;
        end else if (step) begin
          cnt <= last ? '0 : cnt + 1'b1;
        end
        if (last) begin
          gap_cnt <= GAP_INIT;
        end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
          gap_cnt <= gap_cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready  = clr_n && (state == ST_IDLE);
    ser_valid = (state == ST_SHIFT) && !hold;
    busy      = (state != ST_IDLE);
    ser_out   = q[WIDTH-1];
    bit_idx   = cnt;
    done      = done_q;
  end

endmodule

// File: tb/tb_piso_frame_ctrl.sv
// Scoreboard bench for piso_frame_ctrl: expected serial bits are queued on
// each accepted word and popped whenever the DUT flags ser_valid.
module tb_piso_frame_ctrl;

  localparam int   WIDTH = 4;
  localparam int   GAP   = 1;
  localparam logic FILL  = 1'b0;

  logic             CP = 1'b0;
  logic             clr_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             hold = 1'b0;
  logic             abort = 1'b0;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;
  logic [1:0]       bit_idx;

  typedef struct {
    logic b;
    int   idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   d0;
  int   gap_len;

  piso_frame_ctrl #(
    .WIDTH (WIDTH),
    .GAP   (GAP),
    .FILL  (FILL)
  ) dut (
    .CP        (CP),
    .clr_n     (clr_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .hold      (hold),
    .abort     (abort),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done),
    .bit_idx   (bit_idx)
  );

  always #5 CP = ~CP;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // state is stable between falling edges; sample on the rising edge
  always @(posedge CP) begin
    if (done) done_cnt++;
    if (ser_valid) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'(sb.size()), 1);
      end else begin
        mon_e = sb.pop_front();
        check_val("ser_out", ser_out, mon_e.b);
        check_val("bit_idx", bit_idx, mon_e.idx);
      end
    end
  end

  task automatic tick();
    @(negedge CP);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) sb.push_back('{w[i], WIDTH - 1 - i});
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    bit ok;
    ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (in_ready && !abort) begin
        push_word(w);
        ok = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    check_val("send_accept", ok, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    check_val("idle_reached", !busy, 1);
  endtask

  initial begin
    // reset values
    repeat (2) tick();
    check_val("rst_ser_valid", ser_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ser_out", ser_out, 0);
    check_val("rst_bit_idx", bit_idx, 0);
    clr_n = 1'b1;
    #1;
    check_val("rst_in_ready", in_ready, 1);
    tick();

    // single frame 1011 with cycle-exact timing
    d0 = done_cnt;
    send(4'b1011);
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) check_val("t2_ready_low", in_ready, 0);
      if (c == 5) begin
        check_val("t2_done", done, 1);
        check_val("t2_gap_valid", ser_valid, 0);
      end
      if (c == 6) begin
        check_val("t2_ready_back", in_ready, 1);
        check_val("t2_done_clear", done, 0);
      end
      tick();
    end
    check_val("t2_done_cnt", done_cnt - d0, 1);

    // back-to-back frames with in_valid held high
    d0 = done_cnt;
    in_data  = 4'b1011;
    in_valid = 1'b1;
    #1;
    check_val("t3_ready", in_ready, 1);
    push_word(4'b1011);
    tick();
    in_data = 4'b0110;
    repeat (4) tick();
    gap_len = 0;
    for (int i = 0; i < 20; i++) begin
      gap_len++;
      if (in_ready) break;
      tick();
    end
    check_val("t3_gap_len", gap_len, GAP + 1);
    push_word(4'b0110);
    tick();
    in_valid = 1'b0;
    wait_idle();
    repeat (2) tick();
    check_val("t3_done_cnt", done_cnt - d0, 2);

    // hold for 3 cycles at bit 2 of 1001
    d0 = done_cnt;
    send(4'b1001);
    repeat (2) tick();
    check_val("t4_idx_at_hold", bit_idx, 2);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("t4_hold_valid", ser_valid, 0);
      check_val("t4_hold_idx", bit_idx, 2);
      tick();
    end
    hold = 1'b0;
    wait_idle();
    repeat (2) tick();
    check_val("t4_done_cnt", done_cnt - d0, 1);

    // abort together with hold during bit 1
    d0 = done_cnt;
    send(4'b1011);
    tick();
    abort = 1'b1;
    hold  = 1'b1;
    #1;
    check_val("t5_abort_valid", ser_valid, 0);
    tick();
    abort = 1'b0;
    hold  = 1'b0;
    #1;
    check_val("t5_busy", busy, 0);
    check_val("t5_ready", in_ready, 1);
    check_val("t5_q_cleared", ser_out, 0);
    check_val("t5_idx", bit_idx, 0);
    check_val("t5_sb_left", 32'(sb.size()), 3);
    sb.delete();
    repeat (3) tick();
    check_val("t5_no_done", done_cnt - d0, 0);
    send(4'b1111);
    wait_idle();
    repeat (2) tick();
    check_val("t5_done_after", done_cnt - d0, 1);

    // in_valid/in_data toggling during a frame is ignored
    d0 = done_cnt;
    send(4'b1100);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 4'b0000;
      tick();
    end
    in_valid = 1'b0;
    wait_idle();
    repeat (2) tick();
    check_val("t6_done_cnt", done_cnt - d0, 1);
    check_val("t6_sb_empty", 32'(sb.size()), 0);

    // asynchronous reset during bit 2
    d0 = done_cnt;
    send(4'b1011);
    repeat (2) tick();
    check_val("t1_idx_before", bit_idx, 2);
    clr_n = 1'b0;
    #1;
    check_val("t1_ser_valid", ser_valid, 0);
    check_val("t1_busy", busy, 0);
    check_val("t1_done", done, 0);
    check_val("t1_ser_out", ser_out, 0);
    check_val("t1_sb_left", 32'(sb.size()), 2);
    sb.delete();
    tick();
    clr_n = 1'b1;
    #1;
    check_val("t1_ready", in_ready, 1);
    repeat (6) tick();
    check_val("t1_no_done", done_cnt - d0, 0);

    check_val("final_sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
